// File: rtl/aec_pkg.sv
// Shared constants and types for the ASCII expression evaluator: character codes,
// token/operator encodings, controller states and error codes.
package aec_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_A   = 8'h61;
  localparam logic [7:0] CH_F   = 8'h66;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_LP  = 8'h28;
  localparam logic [7:0] CH_RP  = 8'h29;
  localparam logic [7:0] CH_EQ  = 8'h3D;
  localparam logic [7:0] CH_SP  = 8'h20;

  // A token is {kind, DW-bit payload}; operator tokens carry an op_e in the low bits.
  typedef enum logic {TK_NUM = 1'b0, TK_OP = 1'b1} tok_kind_e;

  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_LP, OP_RP} op_e;

  typedef enum logic [2:0] {S_RECV, S_CONV, S_FLUSH, S_EVAL, S_DONE} state_e;

  typedef enum logic [2:0] {
    E_NONE  = 3'd0,
    E_TOK   = 3'd1,
    E_STK   = 3'd2,
    E_PAREN = 3'd3,
    E_SYN   = 3'd4,
    E_CHAR  = 3'd5
  } err_e;

  // Returns {is_hex_digit, nibble}; lowercase hex only.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= CH_0 && c <= CH_9) return {1'b1, 4'(c - CH_0)};
    if (c >= CH_A && c <= CH_F) return {1'b1, 4'(c - CH_A + 8'd10)};
    return 5'd0;
  endfunction

endpackage

// File: rtl/aec_lifo.sv
// Register-file stack. pop_n entries are removed before an optional push lands,
// so pop_n=2 with push folds a binary operation into a single cycle.
module aec_lifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [1:0]                   pop_n,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [W-1:0]                 nxt,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = cnt_q - CW'(pop_n);
    cnt_d = clr ? '0 : base + CW'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[AW'(base)] <= din;
  end

  assign top   = (cnt_q == '0)       ? '0 : mem_q[AW'(cnt_q - CW'(1))];
  assign nxt   = (cnt_q < CW'(2))    ? '0 : mem_q[AW'(cnt_q - CW'(2))];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/aec_param_eval.sv
// ASCII infix calculator: tokenises hex operands and + - * ( ), converts to postfix
// with a shunting-yard pass, evaluates on a value stack and returns one result per '='.
module aec_param_eval
  import aec_pkg::*;
#(
  parameter int DW     = 16,
  parameter int TOKENS = 32,
  parameter int STK    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    ascii_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          err,
  output logic [2:0]    err_code
);
  localparam int TW = $clog2(TOKENS + 1);
  localparam int IW = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam int SW = $clog2(STK + 1);
  localparam int KW = DW + 1;

  logic [KW-1:0] tok_buf_q [TOKENS];
  logic [KW-1:0] pf_buf_q  [TOKENS];

  state_e        state_q, state_d;
  err_e          err_q, err_d;
  logic [DW-1:0] acc_q, acc_d, result_q, result_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tok_cnt_q, tok_cnt_d, tidx_q, tidx_d, pf_cnt_q, pf_cnt_d;

  logic          tw0_en, tw1_en, pf_we, emit_op;
  logic [IW-1:0] tw0_idx, tw1_idx;
  logic [KW-1:0] tw0_dat, tw1_dat, pf_wdat, tok, pfk;

  logic          op_push, op_pop, op_empty, op_full, stk_clr;
  logic [2:0]    op_din, op_top, op_nxt;
  logic [SW-1:0] op_cnt;
  logic          v_push, v_empty, v_full;
  logic [1:0]    v_pop_n;
  logic [DW-1:0] v_din, v_top, v_nxt;
  logic [SW-1:0] v_cnt;
  logic          unused_op_stat;

  logic       accept, is_dig, is_opc, is_eq, is_sp, legal, close;
  logic [4:0] hex;
  op_e        opc;

  assign accept = in_valid && (state_q == S_RECV);
  assign hex    = hex_val(ascii_in);
  assign is_dig = hex[4];
  assign is_eq  = (ascii_in == CH_EQ);
  assign is_sp  = (ascii_in == CH_SP);
  assign legal  = is_dig || is_opc || is_eq || is_sp;
  assign close  = pend_q && !is_dig;
  assign tok    = tok_buf_q[IW'(tidx_q)];
  assign pfk    = pf_buf_q[IW'(tidx_q)];
  assign unused_op_stat = ^{op_nxt, op_cnt, v_empty};

  always_comb begin
    opc    = OP_ADD;
    is_opc = 1'b1;
    case (ascii_in)
      CH_ADD:  opc = OP_ADD;
      CH_SUB:  opc = OP_SUB;
      CH_MUL:  opc = OP_MUL;
      CH_LP:   opc = OP_LP;
      CH_RP:   opc = OP_RP;
      default: is_opc = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    acc_d     = acc_q;
    pend_d    = pend_q;
    result_d  = result_q;
    tok_cnt_d = tok_cnt_q;
    tidx_d    = tidx_q;
    pf_cnt_d  = pf_cnt_q;
    tw0_en    = 1'b0;
    tw1_en    = 1'b0;
    tw0_idx   = IW'(tok_cnt_q);
    tw1_idx   = IW'(tok_cnt_q + TW'(close));
    tw0_dat   = {TK_NUM, acc_q};
    tw1_dat   = {TK_OP, DW'(opc)};
    pf_we     = 1'b0;
    pf_wdat   = tok;
    emit_op   = 1'b0;
    op_push   = 1'b0;
    op_pop    = 1'b0;
    op_din    = tok[2:0];
    v_push    = 1'b0;
    v_pop_n   = 2'd0;
    v_din     = pfk[DW-1:0];
    stk_clr   = 1'b0;

    case (state_q)
      S_RECV: if (accept) begin
        if (is_dig) begin
          acc_d  = (acc_q << 4) | DW'(hex[3:0]);
          pend_d = 1'b1;
        end else begin
          acc_d  = '0;
          pend_d = 1'b0;
        end
        // Once an error is latched the rest of the line is drained without writing tokens.
        if (err_q == E_NONE) begin
          if (!legal) err_d = E_CHAR;
          else if (int'(tok_cnt_q) + int'(close) + int'(is_opc) > TOKENS) err_d = E_TOK;
          else begin
            tw0_en    = close;
            tw1_en    = is_opc;
            tok_cnt_d = tok_cnt_q + TW'(close) + TW'(is_opc);
          end
        end
        if (is_eq) begin
          tidx_d  = '0;
          state_d = (err_d != E_NONE) ? S_DONE : S_CONV;
        end
      end

      S_CONV: begin
        if (tidx_q == tok_cnt_q) state_d = S_FLUSH;
        else if (tok[DW] == TK_NUM) begin
          pf_we    = 1'b1;
          pf_cnt_d = pf_cnt_q + TW'(1);
          tidx_d   = tidx_q + TW'(1);
        end else begin
          case (tok[2:0])
            OP_LP:
              if (op_full) err_d = E_STK;
              else begin op_push = 1'b1; tidx_d = tidx_q + TW'(1); end
            OP_RP:
              if (op_empty) err_d = E_PAREN;
              else if (op_top == OP_LP) begin op_pop = 1'b1; tidx_d = tidx_q + TW'(1); end
              else emit_op = 1'b1;
            OP_MUL:
              if (!op_empty && op_top == OP_MUL) emit_op = 1'b1;
              else if (op_full) err_d = E_STK;
              else begin op_push = 1'b1; tidx_d = tidx_q + TW'(1); end
            default:
              if (!op_empty && op_top != OP_LP) emit_op = 1'b1;
              else if (op_full) err_d = E_STK;
              else begin op_push = 1'b1; tidx_d = tidx_q + TW'(1); end
          endcase
        end
      end

      S_FLUSH: begin
        if (op_empty) begin
          state_d = S_EVAL;
          tidx_d  = '0;
        end else if (op_top == OP_LP) err_d = E_PAREN;
        else emit_op = 1'b1;
      end

      S_EVAL: begin
        if (tidx_q == pf_cnt_q) begin
          if (v_cnt != SW'(1)) err_d = E_SYN;
          else begin
            result_d = v_top;
            state_d  = S_DONE;
          end
        end else if (pfk[DW] == TK_NUM) begin
          if (v_full) err_d = E_STK;
          else begin v_push = 1'b1; tidx_d = tidx_q + TW'(1); end
        end else if (v_cnt < SW'(2)) err_d = E_SYN;
        else begin
          v_pop_n = 2'd2;
          v_push  = 1'b1;
          tidx_d  = tidx_q + TW'(1);
          case (pfk[2:0])
            OP_SUB:  v_din = v_nxt - v_top;
            OP_MUL:  v_din = v_nxt * v_top;
            default: v_din = v_nxt + v_top;
          endcase
        end
      end

      S_DONE: if (out_ready) begin
        state_d   = S_RECV;
        err_d     = E_NONE;
        acc_d     = '0;
        pend_d    = 1'b0;
        result_d  = '0;
        tok_cnt_d = '0;
        tidx_d    = '0;
        pf_cnt_d  = '0;
        stk_clr   = 1'b1;
      end

      default: state_d = S_RECV;
    endcase

    if (emit_op) begin
      op_pop   = 1'b1;
      pf_we    = 1'b1;
      pf_wdat  = {TK_OP, DW'(op_top)};
      pf_cnt_d = pf_cnt_q + TW'(1);
    end

    if ((state_q == S_CONV || state_q == S_FLUSH || state_q == S_EVAL) && err_d != E_NONE) begin
      state_d  = S_DONE;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RECV;
      err_q     <= E_NONE;
      acc_q     <= '0;
      pend_q    <= 1'b0;
      result_q  <= '0;
      tok_cnt_q <= '0;
      tidx_q    <= '0;
      pf_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      result_q  <= result_d;
      tok_cnt_q <= tok_cnt_d;
      tidx_q    <= tidx_d;
      pf_cnt_q  <= pf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tw0_en) tok_buf_q[tw0_idx] <= tw0_dat;
    if (tw1_en) tok_buf_q[tw1_idx] <= tw1_dat;
    if (pf_we)  pf_buf_q[IW'(pf_cnt_q)] <= pf_wdat;
  end

  aec_lifo #(.W(3), .DEPTH(STK)) u_op_stk (
    .clk   (clk),
    .rst   (rst),
    .clr   (stk_clr),
    .push  (op_push),
    .pop_n ({1'b0, op_pop}),
    .din   (op_din),
    .top   (op_top),
    .nxt   (op_nxt),
    .empty (op_empty),
    .full  (op_full),
    .count (op_cnt)
  );

  aec_lifo #(.W(DW), .DEPTH(STK)) u_val_stk (
    .clk   (clk),
    .rst   (rst),
    .clr   (stk_clr),
    .push  (v_push),
    .pop_n (v_pop_n),
    .din   (v_din),
    .top   (v_top),
    .nxt   (v_nxt),
    .empty (v_empty),
    .full  (v_full),
    .count (v_cnt)
  );

  assign in_ready  = (state_q == S_RECV);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = (err_q != E_NONE);
  assign err_code  = err_q;

endmodule

// File: tb/tb_aec_param_eval.sv
// Directed bench for aec_param_eval: three instances (default, DW=8, TOKENS=8)
// share one character driver; sel picks which one is being exercised.
module tb_aec_param_eval;

  logic        clk, rst;
  logic        in_valid, out_ready;
  logic [7:0]  ascii_in;
  int          sel;
  logic [2:0]  iv, orr, in_ready_v, out_valid_v, err_v;
  logic [2:0]  ec_v [3];
  logic [15:0] result_a, result_c;
  logic [7:0]  result_b;
  int          n_chk, n_err;

  assign iv[0]  = in_valid && sel == 0;
  assign iv[1]  = in_valid && sel == 1;
  assign iv[2]  = in_valid && sel == 2;
  assign orr[0] = out_ready && sel == 0;
  assign orr[1] = out_ready && sel == 1;
  assign orr[2] = out_ready && sel == 2;

  aec_param_eval u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(in_ready_v[0]), .ascii_in(ascii_in),
    .out_valid(out_valid_v[0]), .out_ready(orr[0]), .result(result_a), .err(err_v[0]),
    .err_code(ec_v[0]));

  aec_param_eval #(.DW(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(in_ready_v[1]), .ascii_in(ascii_in),
    .out_valid(out_valid_v[1]), .out_ready(orr[1]), .result(result_b), .err(err_v[1]),
    .err_code(ec_v[1]));

  aec_param_eval #(.TOKENS(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(in_ready_v[2]), .ascii_in(ascii_in),
    .out_valid(out_valid_v[2]), .out_ready(orr[2]), .result(result_c), .err(err_v[2]),
    .err_code(ec_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_res();
    case (sel)
      0:       return result_a;
      1:       return {8'h00, result_b};
      default: return result_c;
    endcase
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int n;
      n = 0;
      @(negedge clk);
      ascii_in = s[i];
      in_valid = 1'b1;
      while (!in_ready_v[sel] && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready_v[sel]) begin
        chk("in_ready_timeout", in_ready_v[sel], 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic get(output logic [15:0] r, output logic e, output logic [2:0] c);
    int n, lim;
    n   = 0;
    lim = (sel == 2) ? 2*8 + 16 + 2 : 2*32 + 16 + 2;
    @(negedge clk);
    while (!out_valid_v[sel] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid", out_valid_v[sel], 1);
    chk("latency", n <= lim, 1);
    r = cur_res();
    e = err_v[sel];
    c = ec_v[sel];
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input int s, input string ex, input logic [15:0] er,
                     input logic [2:0] ec, input string tag);
    logic [15:0] r;
    logic        e;
    logic [2:0]  c;
    sel = s;
    send(ex);
    get(r, e, c);
    chk({tag, "_res"}, r, er);
    chk({tag, "_err"}, e, ec != 3'd0);
    chk({tag, "_code"}, c, ec);
  endtask

  initial begin
    logic [15:0] r;
    logic        e;
    logic [2:0]  c;
    string       deep;
    n_chk = 0; n_err = 0;
    sel = 0; in_valid = 1'b0; out_ready = 1'b0; ascii_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready_v[0], 1);
    chk("rst_out_valid", out_valid_v[0], 0);
    chk("rst_result", result_a, 0);
    chk("rst_err", err_v[0], 0);
    chk("rst_code", ec_v[0], 0);

    run(0, "12+3*4=",   16'h001E, 3'd0, "prec");
    run(0, "(1+2)*3=",  16'h0009, 3'd0, "paren");
    run(0, "2-5=",      16'hFFFD, 3'd0, "neg");
    run(1, "ff*ff=",    16'h0001, 3'd0, "mul8");
    run(1, "123=",      16'h0023, 3'd0, "trunc8");
    run(0, "a-3-2=",    16'h0005, 3'd0, "lassoc");
    run(0, "ffff + 1=", 16'h0000, 3'd0, "wrap_sp");
    run(0, "(1+2=",     16'h0000, 3'd3, "unbal");
    run(0, "1+*2=",     16'h0000, 3'd4, "syntax");
    run(0, "=",         16'h0000, 3'd4, "empty");

    // Bad character: no result before '=' arrives.
    sel = 0;
    send("1g2");
    repeat (5) @(negedge clk);
    chk("badch_no_vld", out_valid_v[0], 0);
    chk("badch_rdy", in_ready_v[0], 1);
    send("=");
    get(r, e, c);
    chk("badch_res", r, 0);
    chk("badch_code", c, 3'd5);

    // Consumer stall in DONE.
    sel = 0;
    send("5*5=");
    begin
      int n;
      n = 0;
      while (!out_valid_v[0] && n < 300) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_vld", out_valid_v[0], 1);
      chk("stall_res", result_a, 16'h0019);
      chk("stall_rdy", in_ready_v[0], 0);
    end
    get(r, e, c);
    chk("stall_final", r, 16'h0019);
    run(0, "3+4=", 16'h0007, 3'd0, "after_stall");

    run(2, "1+2+3+4=",   16'h000A, 3'd0, "tok_full");
    run(2, "1+2+3+4+5=", 16'h0000, 3'd1, "tok_ovf");

    deep = "";
    for (int i = 0; i < 17; i++) deep = {deep, "("};
    run(0, {deep, "1="}, 16'h0000, 3'd2, "stk_ovf");

    // Reset while converting.
    sel = 0;
    send("1+2*3=");
    @(negedge clk);
    chk("conv_rdy", in_ready_v[0], 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", in_ready_v[0], 1);
    chk("mid_rst_vld", out_valid_v[0], 0);
    chk("mid_rst_res", result_a, 0);
    chk("mid_rst_err", err_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_vld", out_valid_v[0], 0);
    run(0, "7*6=", 16'h002A, 3'd0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
